aucohl_fifo_th: RTL and testbench
=================================

AUCOHL_FIFO_TH -- requirements
Module: aucohl_fifo_th

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 4, address width; DEPTH = 2**AW entries, all usable.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rd  input  1  read request; pops head entry when accepted.
REQ-006 wr  input  1  write request; pushes wdata when accepted.
REQ-007 wdata  input  DW  write data.
REQ-008 flush  input  1  synchronous clear of contents.
REQ-009 threshold  input  AW+1  programmable level threshold.
REQ-010 flags_clr  input  1  clears sticky error flags.
REQ-011 rdata  output  DW  head entry, first-word fall-through; undefined when empty.
REQ-012 empty  output  1  level == 0.
REQ-013 full  output  1  level == DEPTH.
REQ-014 level  output  AW+1  entry count, 0..DEPTH.
REQ-015 at_th  output  1  level >= threshold.
REQ-016 overflow  output  1  sticky: write attempted and rejected.
REQ-017 underflow  output  1  sticky: read attempted and rejected.

Function
REQ-018 Storage: DEPTH x DW array; write port clocked; rdata = array[rd_ptr] combinationally.
REQ-019 Pointers rd_ptr, wr_ptr: AW bits, wrap DEPTH-1 -> 0.
REQ-020 Accept rules: rd_ok = rd & ~empty; wr_ok = wr & (~full | rd_ok).
REQ-021 wr_ok: array[wr_ptr] <= wdata, wr_ptr += 1.
REQ-022 rd_ok: rd_ptr += 1.
REQ-023 Level: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-024 Full with rd & wr: both accepted, level stays DEPTH, full stays 1, no overflow.
REQ-025 Empty with rd & wr: write accepted, read rejected, level -> 1, underflow set.
REQ-026 Rejected write (wr & ~wr_ok): contents unchanged, overflow <= 1 next cycle.
REQ-027 Rejected read (rd & ~rd_ok): pointers unchanged, underflow <= 1 next cycle.
REQ-028 flush: next cycle rd_ptr = wr_ptr = 0, level = 0; overrides rd/wr same cycle; no flag set by rd/wr in that cycle.
REQ-029 flags_clr: overflow, underflow <= 0; a set event in the same cycle wins.
REQ-030 empty, full, level, at_th: derived from registered level; valid the cycle after any change, no extra latency.
REQ-031 at_th: unsigned compare; threshold 0 -> always 1; threshold > DEPTH -> always 0.
REQ-032 threshold may change any cycle; at_th follows combinationally.
REQ-033 Array contents not reset; unread data after flush never visible on valid reads.

Reset
REQ-034 rst_n low: immediately rd_ptr = wr_ptr = 0, level = 0, empty = 1, full = 0, overflow = underflow = 0, at_th = (threshold == 0).
REQ-035 Reset mid-operation: any in-flight rd/wr discarded; first accepted write after release lands at entry 0.
REQ-036 Outputs stable from assertion until the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Fill, AW=4: 16 writes 0x00..0x0F -> level 16, full 1; 17th write -> overflow 1, level 16; drain 16 reads -> rdata 0x00..0x0F in order, empty 1.
REQ-038 Wrap: 10 writes, 10 reads, 10 writes 0xA0..0xA9 -> reads return 0xA0..0xA9; level 10 -> 0.
REQ-039 Boundaries: full with rd & wr 0x55 -> level 16, no overflow, 0x55 read last; empty with rd & wr 0x33 -> level 1, underflow 1, rdata 0x33.
REQ-040 Threshold 5: at_th 0 at levels 0..4, 1 at 5..16; threshold 17 -> at_th 0 at level 16.
REQ-041 Flush at level 7 with simultaneous wr: next cycle level 0, empty 1, no write stored; flags unchanged. flags_clr with simultaneous rejected read -> underflow stays 1.
REQ-042 rst_n low mid-burst at level 9 -> level 0, empty 1, flags 0 without a clock edge; next write 0x77 -> rdata 0x77.

Source files
------------

// File: rtl/aucohl_fifo_th.sv
// Synchronous FIFO with first-word fall-through read, programmable level
// threshold and sticky overflow/underflow flags.
module aucohl_fifo_th #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  input  logic [AW:0]   threshold,
  input  logic          flags_clr,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          at_th,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   level_reg;
  logic          ovf_reg, unf_reg;

  logic rd_ok, wr_ok, rd_do, wr_do, ovf_set, unf_set;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == DEPTH_L);
  assign level = level_reg;
  assign at_th = (level_reg >= threshold);
  assign rdata = mem[rd_ptr_reg];
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Flush swallows any rd/wr in its cycle, including their error reporting.
  assign rd_do   = rd_ok & ~flush;
  assign wr_do   = wr_ok & ~flush;
  assign ovf_set = wr & ~wr_ok & ~flush;
  assign unf_set = rd & ~rd_ok & ~flush;

  always_ff @(posedge clk) begin
    if (rst_n && wr_do) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (rd_do) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_do) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      case ({wr_do, rd_do})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // A new error event in the same cycle as flags_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (ovf_set)        ovf_reg <= 1'b1;
      else if (flags_clr) ovf_reg <= 1'b0;
      if (unf_set)        unf_reg <= 1'b1;
      else if (flags_clr) unf_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Self-checking bench for aucohl_fifo_th: table-driven fill/threshold vectors,
// directed corner sequences and randomized traffic against a queue model.
module tb_aucohl_fifo_th;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd = 1'b0, wr = 1'b0, flush = 1'b0, flags_clr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW:0]   threshold = '0;
  logic [DW-1:0] rdata;
  logic          empty, full, at_th, overflow, underflow;
  logic [AW:0]   level;

  aucohl_fifo_th #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .wdata(wdata), .flush(flush),
    .threshold(threshold), .flags_clr(flags_clr), .rdata(rdata), .empty(empty),
    .full(full), .level(level), .at_th(at_th), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, flags as plain bits.
  logic [DW-1:0] mq[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    logic rd, wr; logic [DW-1:0] d; logic fl, clr; logic [AW:0] th;
    int lvl; logic fu, em, at, ov, un;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [DW-1:0] d,
                            input logic f, input logic c);
    bit rok, wok;
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (f) begin
      mq.delete();
      return;
    end
    rok = r && mq.size() > 0;
    wok = w && (mq.size() < DEPTH || rok);
    if (w && !wok) m_ovf = 1'b1;
    if (r && !rok) m_unf = 1'b1;
    if (rok) void'(mq.pop_front());
    if (wok) mq.push_back(d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".at_th"}, 32'(at_th), 32'(mq.size() >= int'(threshold)));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    if (mq.size() > 0) chk({tag, ".rdata"}, 32'(rdata), 32'(mq[0]));
  endtask

  task automatic apply(input string tag, input logic r, input logic w, input logic [DW-1:0] d,
                       input logic f = 1'b0, input logic c = 1'b0);
    rd = r; wr = w; wdata = d; flush = f; flags_clr = c;
    model_step(r, w, d, f, c);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; flush = 1'b0; flags_clr = 1'b0;
    $display("txn %s rd=%0b wr=%0b wdata=%02h flush=%0b clr=%0b -> level=%0d rdata=%02h ovf=%0b unf=%0b",
             tag, r, w, d, f, c, level, rdata, overflow, underflow);
    check_model(tag);
  endtask

  initial begin
    vec_t v;
    int wp;

    // Reset state, seen without any clock edge.
    #2;
    chk("rst.level", 32'(level), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.flags", 32'({overflow, underflow}), 0);
    chk("rst.at_th_th0", 32'(at_th), 1);
    threshold = 5'd3;
    #1;
    chk("rst.at_th_th3", 32'(at_th), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: fill with threshold 5, one rejected write, then threshold edges.
    for (int i = 0; i < DEPTH; i++) begin
      v = '{rd:0, wr:1, d:DW'(i), fl:0, clr:0, th:5'd5, lvl:i + 1, fu:(i == DEPTH - 1),
            em:0, at:(i + 1 >= 5), ov:0, un:0};
      vecs.push_back(v);
    end
    vecs.push_back('{rd:0, wr:1, d:8'hEE, fl:0, clr:0, th:5'd5, lvl:16, fu:1, em:0, at:1, ov:1, un:0});
    vecs.push_back('{rd:0, wr:0, d:8'h00, fl:0, clr:0, th:5'd17, lvl:16, fu:1, em:0, at:0, ov:1, un:0});
    vecs.push_back('{rd:0, wr:0, d:8'h00, fl:0, clr:1, th:5'd16, lvl:16, fu:1, em:0, at:1, ov:0, un:0});
    vecs.push_back('{rd:0, wr:0, d:8'h00, fl:0, clr:0, th:5'd31, lvl:16, fu:1, em:0, at:0, ov:0, un:0});
    foreach (vecs[i]) begin
      threshold = vecs[i].th;
      apply($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].d, vecs[i].fl, vecs[i].clr);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d.flags", i), 32'({full, empty, at_th, overflow, underflow}),
          32'({vecs[i].fu, vecs[i].em, vecs[i].at, vecs[i].ov, vecs[i].un}));
    end

    // Drain in order, threshold 5 seen on the way down.
    threshold = 5'd5;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.rdata", 32'(rdata), 32'(i));
      apply("drain", 1'b1, 1'b0, 8'h00);
      chk("drain.at_th", 32'(at_th), 32'(DEPTH - 1 - i >= 5));
    end
    chk("drain.empty", 32'(empty), 1);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) apply("wrap.w1", 1'b0, 1'b1, DW'(8'h10 + i));
    for (int i = 0; i < 10; i++) apply("wrap.r1", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) apply("wrap.w2", 1'b0, 1'b1, DW'(8'hA0 + i));
    chk("wrap.level10", 32'(level), 10);
    for (int i = 0; i < 10; i++) begin
      chk("wrap.rdata", 32'(rdata), 32'(8'hA0 + i));
      apply("wrap.r2", 1'b1, 1'b0, 8'h00);
    end
    chk("wrap.level0", 32'(level), 0);

    // Full with simultaneous rd & wr.
    for (int i = 0; i < DEPTH; i++) apply("bnd.fill", 1'b0, 1'b1, DW'(i));
    apply("bnd.full_rw", 1'b1, 1'b1, 8'h55);
    chk("bnd.full_lvl", 32'(level), 16);
    chk("bnd.full_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) apply("bnd.rd", 1'b1, 1'b0, 8'h00);
    chk("bnd.last55", 32'(rdata), 32'h55);
    apply("bnd.rd_last", 1'b1, 1'b0, 8'h00);
    // Empty with simultaneous rd & wr.
    apply("bnd.empty_rw", 1'b1, 1'b1, 8'h33);
    chk("bnd.empty_lvl", 32'(level), 1);
    chk("bnd.empty_unf", 32'(underflow), 1);
    chk("bnd.empty_rdata", 32'(rdata), 32'h33);
    apply("bnd.rd33", 1'b1, 1'b0, 8'h00);

    // Flush at level 7 with a write in the same cycle; underflow is still set.
    for (int i = 0; i < 7; i++) apply("fl.fill", 1'b0, 1'b1, DW'(8'hC0 + i));
    apply("fl.flush", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fl.level", 32'(level), 0);
    chk("fl.empty", 32'(empty), 1);
    chk("fl.flags", 32'({overflow, underflow}), 32'b01);
    apply("fl.clr_rd", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl.clr_loses", 32'(underflow), 1);
    apply("fl.clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl.clr_wins", 32'(underflow), 0);

    // Async reset mid-burst at level 9 with flags set.
    apply("rst.unf", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) apply("rst.fill", 1'b0, 1'b1, DW'(8'h90 + i));
    wr = 1'b1; wdata = 8'hEE; rd = 1'b1;
    rst_n = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    chk("arst.level", 32'(level), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.flags", 32'({overflow, underflow}), 0);
    @(posedge clk);
    #1;
    chk("arst.held", 32'(level), 0);
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
    @(posedge clk);
    #1;
    check_model("arst.idle");
    apply("arst.w77", 1'b0, 1'b1, 8'h77);
    chk("arst.rdata77", 32'(rdata), 32'h77);

    // Randomized traffic with shifting write/read bias.
    wp = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) wp = $urandom_range(20, 80);
      if ($urandom_range(0, 9) == 0) threshold = 5'($urandom_range(0, 31));
      apply("rand", ($urandom_range(0, 99) >= wp), ($urandom_range(0, 99) < wp),
            DW'($urandom), ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
